// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: sequential FIR filter. One shared multiplier walks the
// delay line one tap per cycle; the result is held until the consumer takes it.
module fir_mac_sequencer #(
    parameter int TAPS = 8,
    parameter int DW   = 16,
    parameter int CW   = 8,
    parameter int AW   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [CW-1:0]     coef_data,
    output logic                     coef_err,
    input  logic                     in_valid,
    input  logic signed [DW-1:0]     in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [AW-1:0]     out_data,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int IW = $clog2(TAPS);
    localparam logic [IW-1:0] LAST   = IW'(TAPS - 1);
    localparam logic [IW:0]   TAPS_W = (IW + 1)'(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

    state_t                  state;
    logic signed [CW-1:0]    coef [TAPS];
    logic signed [DW-1:0]    tap  [TAPS];
    logic [IW-1:0]           idx;
    logic signed [AW-1:0]    acc;
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    sum;
    logic                    addr_ok;

    // Single shared multiplier; product sign-extended into the wrapping accumulator.
    always_comb begin
        prod    = coef[idx] * tap[idx];
        sum     = acc + AW'(prod);
        addr_ok = ({1'b0, coef_addr} < TAPS_W);
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Sequencer FSM: accept a sample, accumulate one tap per cycle, hold the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                tap[k] <= '0;
            end
        end else begin
            coef_err <= coef_we && ((state != IDLE) || !addr_ok);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tap[0] <= in_data;
                        for (int unsigned k = 1; k < TAPS; k++) begin
                            tap[k] <= tap[k-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (idx == LAST) begin
                        idx       <= '0;
                        out_data  <= sum;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient store: identity on reset, writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                coef[k] <= (k == 0) ? {{(CW-1){1'b0}}, 1'b1} : '0;
            end
        end else if (coef_we && (state == IDLE) && addr_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: a tracker mirrors accepted samples
// into a plain-arithmetic FIR model and queues expected results; a monitor
// checks outputs, latency, handshake flags and coef_err pulses.
module tb_fir_mac_sequencer;

    localparam int TAPS = 8;
    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int AW   = 32;
    localparam int IW   = $clog2(TAPS);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 coef_we = 1'b0;
    logic [IW-1:0]        coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 coef_err;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [AW-1:0] out_data;
    logic                 out_ready = 1'b0;
    logic                 busy;

    fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   cyc;
        logic signed [AW-1:0] val;
    } exp_t;

    exp_t                 q[$];
    int                   nchk = 0;
    int                   nerr = 0;
    int                   cyc = 0;
    bit                   rand_rdy = 0;
    logic signed [CW-1:0] m_coef [TAPS];
    logic signed [DW-1:0] hist [TAPS];
    bit                   err_pend = 0;
    bit                   err_exp = 0;
    bit                   prev_valid = 0;
    logic signed [AW-1:0] last_out = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Tracker: observes the handshakes and keeps the reference filter.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                m_coef[k] = (k == 0) ? 8'sd1 : 8'sd0;
                hist[k]   = '0;
            end
            q.delete();
            err_pend = 0;
            err_exp  = 0;
        end else begin
            err_exp  = err_pend;
            err_pend = 0;
            if (coef_we) begin
                if (in_ready && int'(coef_addr) < TAPS) m_coef[coef_addr] = coef_data;
                else err_pend = 1;
            end
            if (in_valid && in_ready) begin
                longint s;
                exp_t   e;
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_data;
                s = 0;
                for (int k = 0; k < TAPS; k++) s += longint'(m_coef[k]) * longint'(hist[k]);
                e.cyc = cyc;
                e.val = s[AW-1:0];
                q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_coef_err", coef_err, 0);
            prev_valid = 0;
        end else begin
            bit bexp;
            bexp = (q.size() > 0) && (cyc > q[0].cyc);
            chk("busy", busy, bexp);
            chk("in_ready", in_ready, !bexp);
            chk("coef_err", coef_err, err_exp);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    if (!prev_valid) chk("latency", cyc - q[0].cyc, TAPS + 1);
                    chk("out_data", out_data, q[0].val);
                    if (out_ready) begin
                        last_out = out_data;
                        void'(q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic signed [DW-1:0] d);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic wcoef(input int a, input int v);
        logic [31:0] av;
        logic [31:0] vv;
        av        = a;
        vv        = v;
        coef_we   = 1'b1;
        coef_addr = av[IW-1:0];
        coef_data = vv[CW-1:0];
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < 400, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk("reset_out_data", out_data, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_coef_err", coef_err, 0);
        tick();

        // Identity coefficients pass samples through.
        out_ready = 1'b1;
        send(16'sd100);
        send(-16'sd5);
        wait_idle();
        chk("identity_last", last_out, -5);

        // Impulse response reads back the coefficients.
        for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
        send(16'sd1);
        for (int k = 1; k < TAPS; k++) send(16'sd0);
        wait_idle();
        chk("impulse_last", last_out, 8);

        // Coefficient write and sample in the same idle cycle.
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 8'sd3;
        send(16'sd10);
        coef_we   = 1'b0;
        wait_idle();
        wcoef(0, 1);

        // Back-pressure in HOLD with a pending sample.
        out_ready = 1'b0;
        send(16'sd42);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        chk("hold_reached", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 16'sd9;
        repeat (5) tick();
        out_ready = 1'b1;
        send(16'sd9);
        wait_idle();

        // Coefficient write during MAC is rejected, then accepted when idle.
        send(16'sd2);
        repeat (2) tick();
        wcoef(3, 99);
        wait_idle();
        send(16'sd3);
        wait_idle();
        wcoef(3, 99);
        send(16'sd4);
        wait_idle();

        // Reset in the middle of a computation.
        send(16'sd5);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        send(16'sd7);
        wait_idle();
        chk("after_reset_out", last_out, 7);

        // Largest-magnitude products accumulate without overflow.
        for (int k = 0; k < TAPS; k++) wcoef(k, -128);
        for (int k = 0; k < TAPS; k++) send(-16'sd32768);
        wait_idle();
        chk("max_accum", last_out, 33554432);

        // Randomised traffic with random back-pressure.
        rand_rdy = 1;
        for (int i = 0; i < 160; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) wcoef($urandom_range(0, TAPS - 1), $urandom_range(0, 255) - 128);
            else if (r < 8) send(16'($urandom));
            else tick();
        end
        rand_rdy  = 0;
        out_ready = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
